// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS core. It steps the shared datapath through
// fetch, decode, execute, memory and writeback, stalls on mem_ready and counts retired instructions.
module mips_multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Op,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCEn,
    output logic [1:0]       PCSrc,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTYPEEX = 4'd7,
        S_RTYPEWB = 4'd8,
        S_BEQEX   = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JEX     = 4'd12
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_pcwrite;
    logic             w_branch;
    logic             w_retire;
    logic [CNT_W-1:0] r_instr_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        w_retire     = 1'b0;
        mem_req      = 1'b0;
        IorD         = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        PCSrc        = 2'b00;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        illegal_op   = 1'b0;

        case (r_state)
            S_IDLE: w_state_next = S_FETCH;
            S_FETCH: begin
                // PC+4 is computed every fetch cycle but only committed with the instruction.
                mem_req   = 1'b1;
                ALUSrcB   = 2'b01;
                IRWrite   = mem_ready;
                w_pcwrite = mem_ready;
                if (mem_ready) w_state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_RTYPE:     w_state_next = S_RTYPEEX;
                    OP_BEQ:       w_state_next = S_BEQEX;
                    OP_ADDI:      w_state_next = S_ADDIEX;
                    OP_J:         w_state_next = S_JEX;
                    default: begin
                        illegal_op   = 1'b1;
                        w_state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                w_state_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) w_state_next = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite     = 1'b1;
                MemtoReg     = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    w_retire     = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_RTYPEEX: begin
                ALUSrcA      = 1'b1;
                ALUOp        = 2'b10;
                w_state_next = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                RegWrite     = 1'b1;
                RegDst       = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_BEQEX: begin
                ALUSrcA      = 1'b1;
                ALUOp        = 2'b01;
                PCSrc        = 2'b01;
                w_branch     = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                w_state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite     = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_JEX: begin
                PCSrc        = 2'b10;
                w_pcwrite    = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The ALU subtraction of a beq resolves in the same cycle, so PCEn stays combinational.
    assign PCEn = w_pcwrite | (w_branch & Zero);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr_count <= '0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class through the FSM
// and checks every output each cycle plus the retired-instruction counter (4-bit, to exercise wrap).
module tb_mips_multicycle_control;

    logic       clk;
    logic       rst;
    logic [5:0] Op;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req, IorD, MemWrite, IRWrite, PCEn, RegWrite, RegDst, MemtoReg, ALUSrcA, illegal_op;
    logic [1:0] PCSrc, ALUSrcB, ALUOp;
    logic [3:0] instr_count;

    int passed = 0;
    int total  = 0;

    mips_multicycle_control #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCEn(PCEn), .PCSrc(PCSrc), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [15:0] obs = {mem_req, IorD, MemWrite, IRWrite, PCEn, PCSrc, RegWrite, RegDst,
                       MemtoReg, ALUSrcA, ALUSrcB, ALUOp, illegal_op};

    // Output bundle in the same bit order as obs.
    function automatic logic [15:0] mk(input logic mr, io, mw, irw, pce, input logic [1:0] pcs,
                                       input logic rw, rd, m2r, sa, input logic [1:0] sb, aop,
                                       input logic ill);
        return {mr, io, mw, irw, pce, pcs, rw, rd, m2r, sa, sb, aop, ill};
    endfunction

    task automatic chk(input string tag, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s outputs=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_cnt(input string tag, input logic [3:0] exp);
        total++;
        assert (instr_count === exp) passed++;
        else $error("FAIL %s instr_count=%0d expected=%0d", tag, instr_count, exp);
    endtask

    // Check the current cycle's outputs, then advance to the next negedge.
    task automatic step(input string tag, input logic [15:0] exp);
        #1;
        chk(tag, exp);
        @(negedge clk);
    endtask

    logic [15:0] E_ZERO, E_FETCH1, E_FETCH0, E_DECODE, E_DECODE_ILL, E_MEMADR, E_MEMRD, E_MEMWB;
    logic [15:0] E_MEMWR, E_RTYPEEX, E_RTYPEWB, E_BEQ1, E_BEQ0, E_ADDIEX, E_ADDIWB, E_JEX;

    initial begin
        E_ZERO       = '0;
        E_FETCH1     = mk(1,0,0,1,1,2'b00,0,0,0,0,2'b01,2'b00,0);
        E_FETCH0     = mk(1,0,0,0,0,2'b00,0,0,0,0,2'b01,2'b00,0);
        E_DECODE     = mk(0,0,0,0,0,2'b00,0,0,0,0,2'b11,2'b00,0);
        E_DECODE_ILL = mk(0,0,0,0,0,2'b00,0,0,0,0,2'b11,2'b00,1);
        E_MEMADR     = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,2'b00,0);
        E_MEMRD      = mk(1,1,0,0,0,2'b00,0,0,0,0,2'b00,2'b00,0);
        E_MEMWB      = mk(0,0,0,0,0,2'b00,1,0,1,0,2'b00,2'b00,0);
        E_MEMWR      = mk(1,1,1,0,0,2'b00,0,0,0,0,2'b00,2'b00,0);
        E_RTYPEEX    = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b00,2'b10,0);
        E_RTYPEWB    = mk(0,0,0,0,0,2'b00,1,1,0,0,2'b00,2'b00,0);
        E_BEQ1       = mk(0,0,0,0,1,2'b01,0,0,0,1,2'b00,2'b01,0);
        E_BEQ0       = mk(0,0,0,0,0,2'b01,0,0,0,1,2'b00,2'b01,0);
        E_ADDIEX     = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,2'b00,0);
        E_ADDIWB     = mk(0,0,0,0,0,2'b00,1,0,0,0,2'b00,2'b00,0);
        E_JEX        = mk(0,0,0,0,1,2'b10,0,0,0,0,2'b00,2'b00,0);

        rst = 1'b0; Op = 6'h00; Zero = 1'b0; mem_ready = 1'b1;

        // Reset held for three cycles, then released.
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", E_ZERO);
        chk_cnt("reset_count", 4'd0);
        rst = 1'b1;
        step("idle", E_ZERO);

        // lw then R-type
        Op = 6'h23;
        step("lw_fetch", E_FETCH1);
        step("lw_decode", E_DECODE);
        step("lw_memadr", E_MEMADR);
        step("lw_memrd", E_MEMRD);
        #1 chk_cnt("lw_count_before", 4'd0);
        step("lw_memwb", E_MEMWB);
        Op = 6'h00;
        #1 chk_cnt("lw_count_after", 4'd1);
        step("r_fetch", E_FETCH1);
        step("r_decode", E_DECODE);
        step("r_ex", E_RTYPEEX);
        step("r_wb", E_RTYPEWB);
        #1 chk_cnt("r_count", 4'd2);

        // beq taken, with PCEn following Zero inside the cycle, then not taken
        Op = 6'h04;
        step("beq_fetch", E_FETCH1);
        step("beq_decode", E_DECODE);
        Zero = 1'b1;
        #1 chk("beq_taken", E_BEQ1);
        Zero = 1'b0;
        #1 chk("beq_zero_drop", E_BEQ0);
        @(negedge clk);
        #1 chk_cnt("beq1_count", 4'd3);
        step("beq2_fetch", E_FETCH1);
        step("beq2_decode", E_DECODE);
        step("beq_not_taken", E_BEQ0);
        #1 chk_cnt("beq2_count", 4'd4);

        // sw with a one-cycle fetch stall and a three-cycle write stall
        Op = 6'h2B; mem_ready = 1'b0;
        step("sw_fetch_stall", E_FETCH0);
        mem_ready = 1'b1;
        step("sw_fetch", E_FETCH1);
        mem_ready = 1'b0;
        step("sw_decode_ready_ignored", E_DECODE);
        step("sw_memadr", E_MEMADR);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("sw_memwr_stall%0d", i), E_MEMWR);
        end
        #1 chk_cnt("sw_count_stalled", 4'd4);
        mem_ready = 1'b1;
        step("sw_memwr_done", E_MEMWR);
        #1 chk_cnt("sw_count", 4'd5);

        // Illegal opcode
        Op = 6'h3F;
        step("ill_fetch", E_FETCH1);
        step("ill_decode", E_DECODE_ILL);
        Op = 6'h08;
        #1 chk_cnt("ill_count", 4'd5);
        step("ill_back_to_fetch", E_FETCH1);

        // addi (fetch just checked)
        step("addi_decode", E_DECODE);
        step("addi_ex", E_ADDIEX);
        step("addi_wb", E_ADDIWB);
        #1 chk_cnt("addi_count", 4'd6);

        // lw aborted by reset during a MEMRD stall
        Op = 6'h23;
        step("abort_fetch", E_FETCH1);
        step("abort_decode", E_DECODE);
        step("abort_memadr", E_MEMADR);
        mem_ready = 1'b0;
        step("abort_memrd_stall", E_MEMRD);
        #1 chk("abort_memrd_stall2", E_MEMRD);
        #2 rst = 1'b0;
        #1;
        chk("abort_outputs", E_ZERO);
        chk_cnt("abort_count", 4'd0);
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1;
        step("abort_idle", E_ZERO);

        // 16 jumps wrap the 4-bit counter back to 0
        Op = 6'h02;
        for (int i = 0; i < 16; i++) begin
            #1 chk_cnt($sformatf("j%0d_count", i), 4'(i));
            step($sformatf("j%0d_fetch", i), E_FETCH1);
            step($sformatf("j%0d_decode", i), E_DECODE);
            step($sformatf("j%0d_ex", i), E_JEX);
        end
        #1 chk_cnt("wrap_count", 4'd0);
        chk("wrap_fetch", E_FETCH1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
